// File: rtl/cr_xer_wb_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : cr_xer_wb_pkg                                                    |
// | Brief   : Op encodings, XER bit positions and queue entry type shared by   |
// |           the CR/XER commit stage.                                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package cr_xer_wb_pkg;

    localparam int CRXOP_W = 3;

    localparam logic [CRXOP_W-1:0] CRXOP_NOP   = 3'd0;
    localparam logic [CRXOP_W-1:0] CRXOP_REC   = 3'd1;
    localparam logic [CRXOP_W-1:0] CRXOP_CMP   = 3'd2;
    localparam logic [CRXOP_W-1:0] CRXOP_MTCRF = 3'd3;
    localparam logic [CRXOP_W-1:0] CRXOP_MTXER = 3'd4;
    localparam logic [CRXOP_W-1:0] CRXOP_MCRXR = 3'd5;

    // Architectural (big-endian) bit numbers; bit 0 is the register MSB.
    localparam int XER_SO = 0;
    localparam int XER_OV = 1;
    localparam int XER_CA = 2;

    localparam int CR_FIELD_WIDTH = 4;

    typedef struct packed {
        logic [CRXOP_W-1:0] op;
        logic [2:0]         alu_d;
        logic [2:0]         cmp_d;
        logic [2:0]         crf;
        logic [7:0]         fxm;
        logic [31:0]        rs;
        logic               ca_we;
        logic               ca_in;
        logic               ov_we;
        logic               ov_in;
    } crx_entry_t;

    // Vector LSB of CR field f when field 0 sits in the top nibble.
    function automatic logic [4:0] crx_field_lsb(input logic [2:0] f);
        return 5'd28 - {f, 2'b00};
    endfunction

    function automatic int crx_bit(input int arch_bit);
        return 31 - arch_bit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cr_xer_wb_crx_apply.sv
// +----------------------------------------------------------------------------+
// | Module  : crx_apply                                                        |
// | Brief   : Combinational (cr, xer, entry) -> (cr_next, xer_next) update.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module crx_apply
    import cr_xer_wb_pkg::*;
(
    input  logic [31:0] i_cr,
    input  logic [31:0] i_xer,
    input  crx_entry_t  i_entry,
    output logic [31:0] o_cr,
    output logic [31:0] o_xer
);

    logic       w_so;
    logic [4:0] w_lsb;

    always_comb begin
        o_cr  = i_cr;
        o_xer = i_xer;
        w_lsb = crx_field_lsb(i_entry.crf);

        if (i_entry.ov_we) o_xer[crx_bit(XER_OV)] = i_entry.ov_in;
        if (i_entry.ca_we) o_xer[crx_bit(XER_CA)] = i_entry.ca_in;
        o_xer[crx_bit(XER_SO)] = o_xer[crx_bit(XER_SO)] | (i_entry.ov_we & i_entry.ov_in);
        w_so = o_xer[crx_bit(XER_SO)];

        case (i_entry.op)
            CRXOP_REC: o_cr[crx_field_lsb(3'd0) +: CR_FIELD_WIDTH] = {i_entry.alu_d, w_so};
            CRXOP_CMP: o_cr[w_lsb +: CR_FIELD_WIDTH] = {i_entry.cmp_d, w_so};
            CRXOP_MTCRF: begin
                for (int i = 0; i < 8; i++) begin
                    if (i_entry.fxm[i]) begin
                        o_cr[crx_field_lsb(3'(i)) +: CR_FIELD_WIDTH] =
                            i_entry.rs[crx_field_lsb(3'(i)) +: CR_FIELD_WIDTH];
                    end
                end
            end
            CRXOP_MTXER: o_xer = i_entry.rs;
            CRXOP_MCRXR: begin
                // Field takes the pre-commit SO/OV/CA, then those bits clear.
                o_cr[w_lsb +: CR_FIELD_WIDTH] = i_xer[31 -: CR_FIELD_WIDTH];
                o_xer[31 -: CR_FIELD_WIDTH]   = '0;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cr_xer_wb.sv
// +----------------------------------------------------------------------------+
// | Module  : cr_xer_wb                                                        |
// | Brief   : In-order CR/XER update queue committing one entry per cycle.     |
// |           Define CR_XER_FWD_EN to forward the head-commit CR on cr_fwd.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module cr_xer_wb
    import cr_xer_wb_pkg::*;
#(
    parameter int unsigned QDEPTH  = 2,
    parameter logic [31:0] CR_RST  = 32'h0000_0000,
    parameter logic [31:0] XER_RST = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CRXOP_W-1:0] in_op,
    input  logic [2:0]         alu_d,
    input  logic [2:0]         cmp_d,
    input  logic [2:0]         in_crf,
    input  logic [7:0]         in_fxm,
    input  logic [31:0]        in_rs,
    input  logic               ca_we,
    input  logic               ca_in,
    input  logic               ov_we,
    input  logic               ov_in,
    input  logic               commit_en,
    input  logic               flush,
    output logic [31:0]        cr,
    output logic [31:0]        xer,
    output logic               busy,
    output logic [31:0]        cr_fwd
);

    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW:0] c_ptr_one = {{PW{1'b0}}, 1'b1};

    logic [PW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0] cr_q, cr_d, xer_q, xer_d;
    crx_entry_t  mem_q [QDEPTH];
    crx_entry_t  mem_d [QDEPTH];

    crx_entry_t  w_in, w_head;
    logic        w_empty, w_full, w_enq, w_commit;
    logic [31:0] w_cr_next, w_xer_next;

    assign w_in     = '{op: in_op, alu_d: alu_d, cmp_d: cmp_d, crf: in_crf, fxm: in_fxm,
                        rs: in_rs, ca_we: ca_we, ca_in: ca_in, ov_we: ov_we, ov_in: ov_in};
    assign w_head   = mem_q[rd_ptr_q[PW-1:0]];
    assign w_empty  = (wr_ptr_q == rd_ptr_q);
    assign w_full   = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign w_enq    = in_valid && !w_full;
    assign w_commit = !w_empty && commit_en;

    crx_apply u_commit_apply (
        .i_cr    (cr_q),
        .i_xer   (xer_q),
        .i_entry (w_head),
        .o_cr    (w_cr_next),
        .o_xer   (w_xer_next)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cr_d     = cr_q;
        xer_d    = xer_q;
        mem_d    = mem_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (w_enq) begin
                mem_d[wr_ptr_q[PW-1:0]] = w_in;
                wr_ptr_d                = wr_ptr_q + c_ptr_one;
            end
            if (w_commit) begin
                rd_ptr_d = rd_ptr_q + c_ptr_one;
                cr_d     = w_cr_next;
                xer_d    = w_xer_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cr_q     <= CR_RST;
            xer_q    <= XER_RST;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cr_q     <= cr_d;
            xer_q    <= xer_d;
        end
    end

    // Payload storage needs no reset; the pointers define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign in_ready = !w_full;
    assign busy     = !w_empty;
    assign cr       = cr_q;
    assign xer      = xer_q;

`ifdef CR_XER_FWD_EN
    logic [31:0] w_fwd_cr, w_fwd_xer;

    crx_apply u_fwd_apply (
        .i_cr    (cr_q),
        .i_xer   (xer_q),
        .i_entry (w_head),
        .o_cr    (w_fwd_cr),
        .o_xer   (w_fwd_xer)
    );

    assign cr_fwd = w_empty ? cr_q : w_fwd_cr;
`else
    assign cr_fwd = cr_q;
`endif

endmodule

`default_nettype wire

// File: doc/cr_xer_wb.md
Name: cr_xer_wb

Overview:
- Condition-register and XER commit stage, directly downstream of the ALU and cmpALU in the execute stage.
- Accepts per-instruction update requests: ALU record-form CR0 bits, cmpALU CRn bits, carry/overflow flags, mtcrf/mtxer/mcrxr.
- Buffers them in a 2-entry in-order queue and commits one per cycle into the architectural 32-bit CR and XER registers.
- Exposes a busy flag so decode can interlock CR/XER readers.

Parameters:
- QDEPTH, 2, update-queue depth; only power-of-two values 2 or 4 are supported.
- CR_RST, 32'h0000_0000, CR reset value.
- XER_RST, 32'h0000_0000, XER reset value.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  update request present.
- in_ready  out  1  queue can accept (not full).
- in_op  in  3  0 NOP, 1 REC (CR0 from alu_d), 2 CMP (field in_crf from cmp_d), 3 MTCRF, 4 MTXER, 5 MCRXR; 6 and 7 reserved.
- alu_d  in  3  {LT,GT,EQ} from ALU.
- cmp_d  in  3  {LT,GT,EQ} from cmpALU.
- in_crf  in  3  target CR field for CMP/MCRXR.
- in_fxm  in  8  mtcrf field mask; bit 0 selects CR0.
- in_rs  in  32  source data for MTCRF/MTXER.
- ca_we, ca_in  in  1,1  carry write enable/value (any op).
- ov_we, ov_in  in  1,1  overflow write enable/value (any op).
- commit_en  in  1  pipeline permits head-entry commit this cycle.
- flush  in  1  discard all queued entries.
- cr  out  32  architectural CR, bit order [0:31].
- xer  out  32  architectural XER; bit 0 SO, bit 1 OV, bit 2 CA.
- busy  out  1  queue non-empty.
- cr_fwd  out  32  see Optional Feature.

Behaviour:
- Reset (rst_n=0 at posedge): cr=CR_RST, xer=XER_RST, queue empty, busy=0, in_ready=1.
- Enqueue: occurs when in_valid && in_ready at posedge. The entry captures all inputs (op, alu_d/cmp_d, crf, fxm, rs, ca/ov fields). NOP entries are still queued; they commit only their ca/ov writes.
- Commit: occurs when busy && commit_en at posedge. The head entry is applied and popped. Results are visible on cr/xer the cycle after the commit edge, so minimum input-to-cr latency is 2 cycles (enqueue edge, then commit edge).
- Order within one commit:
  - OV/CA update first: XER[1]=ov_in if ov_we; XER[2]=ca_in if ca_we.
  - SO is sticky: XER[0] |= (ov_we & ov_in).
  - The CR write then uses the post-update SO as bit 3 of the field.
- REC: CR[0:3] = {alu_d, SO}.
- CMP: CR[4f:4f+3] = {cmp_d, SO}, with f = in_crf.
- MTCRF: for each i with fxm[i]=1, CR[4i:4i+3] = rs[4i:4i+3].
- MTXER: XER = rs. This overrides that entry's ca/ov writes.
- MCRXR: CR field f = XER[0:3] as it stood before this commit; then XER[0:3] = 0.
- Reserved ops: no CR write; XER changes only through that entry's ca/ov writes.
- Simultaneous enqueue and commit:
  - Both happen; occupancy is unchanged.
  - When full, in_ready=0 even if a commit occurs the same cycle (no pass-through).
- Empty queue: commit_en is ignored.
- Flush:
  - Occupancy goes to 0 at the edge; busy=0 next cycle.
  - Flush has priority over enqueue and commit in the same cycle; neither the head entry nor the input is applied.
  - cr/xer are unchanged.
- Pointers are log2(QDEPTH) bits plus one wrap bit, and wrap modulo QDEPTH.
- Reset mid-operation: queue contents are discarded and cr/xer are reloaded with CR_RST/XER_RST.

Optional Feature:
- Macro: CR_XER_FWD_EN.
- Defined: cr_fwd = the cr value that would result from committing the head entry (combinational), or cr when the queue is empty. This lets the following instruction read CR without waiting the extra cycle.
- Undefined: cr_fwd = cr (registered) and no forwarding logic is built.

Decomposition:
- Shared package/define file holds:
  - the in_op encodings (CRXOP_NOP..CRXOP_MCRXR) and width;
  - XER bit positions (XER_SO=0, XER_OV=1, XER_CA=2);
  - CR_FIELD_WIDTH=4.
- One sub-module: crx_apply. It is the combinational function (cr, xer, entry) -> (cr_next, xer_next). The commit path and the CR_XER_FWD_EN forward path both instantiate it.

Test Plan:
- Reset then idle: cr=0, xer=0, busy=0, in_ready=1.
- REC with alu_d=3'b100, ov_we=1, ov_in=1, commit_en=1: two cycles later cr[0:3]=4'b1001, xer[0:2]=3'b110.
- CMP with crf=7, cmp_d=3'b001, SO=0 → cr[28:31]=4'b0010. MTCRF with fxm=8'h81, rs=32'hA000_0005 → cr[0:3]=4'hA, cr[28:31]=4'h5, other fields kept.
- commit_en=0 with 2 enqueues → in_ready=0, busy=1; a 3rd in_valid is not accepted; raising commit_en drains both in order.
- Queue holding 1 entry, flush=1 together with in_valid and commit_en → cr/xer unchanged, busy=0 next cycle.
- xer=32'hE000_0000, MCRXR crf=2 → cr[8:11]=4'hE, xer[0:3]=0.
- With CR_XER_FWD_EN defined, cr_fwd shows the updated field one cycle before cr does.
